ssp_reg_bist: RTL

Parametrised register-access BIST engine for the SSP UART register port. It drives the SSP slave bus (`SSP_SSEL`/`SSP_WnR`/`SSP_RA`/`SSP_DI`/`SSP_EOC`) and samples `SSP_DO`. It runs a reset-value pass and/or a write-readback pass over a masked set of register addresses, counts mismatches and records the first failure. It sits beside the SSP UART in the HDL top and replaces hand-sequenced register checks, with configurable width, register count, read latency and per-address patterns.

---
 rtl/ssp_reg_bist.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ssp_reg_bist.sv
// Register-access BIST engine for the SSP slave bus: reset-value and/or
// write-readback passes over a masked set of addresses, with error capture.
module ssp_reg_bist #(
  parameter int          DW       = 12,
  parameter int          AW       = 3,
  parameter int          NUM_REGS = 5,
  parameter int          READ_LAT = 2,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DW-1:0]       pattern,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic                SSP_SSEL,
  output logic                SSP_WnR,
  output logic                SSP_EOC,
  output logic [AW-1:0]       SSP_RA,
  output logic [DW-1:0]       SSP_DI,
  input  logic [DW-1:0]       SSP_DO,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_cnt,
  output logic [AW-1:0]       first_err_addr,
  output logic [DW-1:0]       first_err_data
);

  localparam int NSLOT = 1 << AW;
  localparam int CW    = $clog2(READ_LAT + 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_SKIP = 3'd2, S_WR = 3'd3,
    S_GAP  = 3'd4, S_RD   = 3'd5, S_CMP  = 3'd6, S_DONE = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  phase_wr_q, phase_wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [DW-1:0]         pattern_q, pattern_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [AW-1:0]         fea_q, fea_d;
  logic [DW-1:0]         fed_q, fed_d;
  logic                  ssel_q, ssel_d, wnr_q, wnr_d, eoc_q, eoc_d;
  logic [AW-1:0]         ra_q, ra_d;
  logic [DW-1:0]         di_q, di_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [NSLOT-1:0]      mask_ext_s;
  logic [DW-1:0]         exp_s;
  logic                  adv_s;

  // Per-register entry state: masked-out registers are skipped in either phase.
  function automatic state_e entry(input logic [AW-1:0] i, input logic wr,
                                   input logic [NSLOT-1:0] m);
    if (!m[i]) begin
      entry = S_SKIP;
    end else if (wr) begin
      entry = S_WR;
    end else begin
      entry = S_RD;
    end
  endfunction

  always_comb begin
    mask_ext_s = '0;
    mask_ext_s[NUM_REGS-1:0] = mask_q;
    exp_s = phase_wr_q ? (pattern_q ^ DW'(idx_q)) : RST_VAL;
  end

  // State register and all datapath/output flops.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;  idx_q <= '0;  phase_wr_q <= 1'b0;  cnt_q <= '0;
      mode_q <= '0;  pattern_q <= '0;  mask_q <= '0;  rdata_q <= '0;
      err_cnt_q <= '0;  fea_q <= '0;  fed_q <= '0;
      ssel_q <= 1'b0;  wnr_q <= 1'b0;  eoc_q <= 1'b0;  ra_q <= '0;  di_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  pass_q <= 1'b0;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  phase_wr_q <= phase_wr_d;  cnt_q <= cnt_d;
      mode_q <= mode_d;  pattern_q <= pattern_d;  mask_q <= mask_d;  rdata_q <= rdata_d;
      err_cnt_q <= err_cnt_d;  fea_q <= fea_d;  fed_q <= fed_d;
      ssel_q <= ssel_d;  wnr_q <= wnr_d;  eoc_q <= eoc_d;  ra_q <= ra_d;  di_q <= di_d;
      busy_q <= busy_d;  done_q <= done_d;  pass_q <= pass_d;
    end
  end

  // Next-state, sequencing and error bookkeeping.
  always_comb begin
    state_d = state_q;  idx_d = idx_q;  phase_wr_d = phase_wr_q;  cnt_d = cnt_q;
    mode_d = mode_q;  pattern_d = pattern_q;  mask_d = mask_q;  rdata_d = rdata_q;
    err_cnt_d = err_cnt_q;  fea_d = fea_q;  fed_d = fed_q;
    adv_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;  pattern_d = pattern;  mask_d = reg_mask;
          err_cnt_d = '0;  fea_d = '0;  fed_d = '0;
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        idx_d = '0;
        cnt_d = '0;
        phase_wr_d = (mode_q == 2'd1);
        state_d = entry({AW{1'b0}}, phase_wr_d, mask_ext_s);
      end
      S_WR: begin
        cnt_d = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CW'(READ_LAT - 1)) begin
          cnt_d = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD: begin
        if (cnt_q == CW'(READ_LAT)) begin
          rdata_d = SSP_DO;
          cnt_d = '0;
          state_d = S_CMP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CMP: begin
        if (rdata_q != exp_s) begin
          err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
          if (err_cnt_q == 8'd0) begin
            fea_d = idx_q;
            fed_d = rdata_q;
          end else begin
            fea_d = fea_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        adv_s = 1'b1;
      end
      S_SKIP: adv_s = 1'b1;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (adv_s) begin
      cnt_d = '0;
      if (idx_q != LAST_IDX) begin
        idx_d = idx_q + AW'(1);
        state_d = entry(idx_d, phase_wr_q, mask_ext_s);
      end else if (!phase_wr_q && mode_q[1]) begin
        phase_wr_d = 1'b1;
        idx_d = '0;
        state_d = entry({AW{1'b0}}, 1'b1, mask_ext_s);
      end else begin
        state_d = S_DONE;
      end
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Registered bus and status outputs, derived from the state being entered.
  always_comb begin
    ssel_d = (state_d == S_WR) || (state_d == S_RD);
    wnr_d  = (state_d == S_WR);
    eoc_d  = (state_d == S_WR);
    if (ssel_d) begin
      ra_d = idx_d;
    end else begin
      ra_d = ra_q;
    end
    if (state_d == S_WR) begin
      di_d = pattern_q ^ DW'(idx_d);
    end else begin
      di_d = di_q;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      pass_d = (err_cnt_d == 8'd0);
    end else if (state_d == S_INIT) begin
      done_d = 1'b0;
      pass_d = 1'b0;
    end else begin
      done_d = done_q;
      pass_d = pass_q;
    end
  end

  assign SSP_SSEL       = ssel_q;
  assign SSP_WnR        = wnr_q;
  assign SSP_EOC        = eoc_q;
  assign SSP_RA         = ra_q;
  assign SSP_DI         = di_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;

endmodule
